btn_pulse: RTL and testbench

Front-end conditioner for the four play buttons. Synchronises each raw board button into `clk`, debounces it with a per-button stable-time counter, and emits a one-cycle press pulse on each debounced rising edge. Its `bnt1`..`bnt4` outputs feed the screen-number controller and the note-judging logic directly; `btn_level` gives the debounced held state for hold notes.

---
 rtl/btn_pulse.sv | 101 ++++++++++
 tb/tb_btn_pulse.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse.sv
// btn_pulse: conditions the four play buttons.
// Each raw button is synchronised into clk and debounced by its own stable-time
// counter. A registered one-cycle press pulse is emitted on every accepted
// 0->1 change. Releases are debounced the same way but never pulse.
module btn_pulse #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int CNT_W        = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn_raw,
   output logic       bnt1,
   output logic       bnt2,
   output logic       bnt3,
   output logic       bnt4,
   output logic [3:0] btn_level,
   output logic       any_press
);

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_t;

   // The counter reaches this value on the last cycle before a new input value
   // is accepted, so it never needs to hold DEBOUNCE_CYC itself and never wraps.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [CNT_W-1:0] r_cnt       [4];
   logic [CNT_W-1:0] w_cntNext   [4];
   state_t           r_state     [4];
   state_t           w_stateNext [4];
   logic [3:0]       r_pulse;
   logic [3:0]       w_pulseNext;
   logic [3:0]       w_level;

   // Two-flop synchroniser bringing the asynchronous buttons into clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // State register: per-channel debounced state, stable-time counter and press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_state[i] <= IDLE;
            r_cnt[i]   <= '0;
         end
         r_pulse <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_state[i] <= w_stateNext[i];
            r_cnt[i]   <= w_cntNext[i];
         end
         r_pulse <= w_pulseNext;
      end
   end

   // Next-state: count while the synchronised input disagrees with the accepted
   // level, flip the state after DEBOUNCE_CYC consecutive disagreeing cycles, and
   // restart the count whenever the input agrees again. A press pulse is scheduled
   // only for an IDLE->HELD flip, so it lands in the first cycle level reads 1.
   always_comb begin
      w_pulseNext = '0;
      for (int i = 0; i < 4; i++) begin
         w_stateNext[i] = r_state[i];
         w_cntNext[i]   = '0;
         if (r_sync2[i] != w_level[i]) begin
            if (r_cnt[i] == CNT_LAST) begin
               w_stateNext[i] = (r_state[i] == IDLE) ? HELD : IDLE;
               w_cntNext[i]   = '0;
            end else begin
               w_cntNext[i]   = r_cnt[i] + CNT_W'(1);
            end
         end
         w_pulseNext[i] = (r_state[i] == IDLE) && (w_stateNext[i] == HELD);
      end
   end

   // Outputs: debounced level straight from the state, pulses straight from their registers.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_level[i] = (r_state[i] == HELD);
      end
      btn_level = w_level;
      bnt1      = r_pulse[0];
      bnt2      = r_pulse[1];
      bnt3      = r_pulse[2];
      bnt4      = r_pulse[3];
      any_press = |r_pulse;
   end

endmodule

// File: tb/tb_btn_pulse.sv
// tb_btn_pulse: self-checking bench for btn_pulse.
// dut1 uses a short debounce time for the detailed behaviour; dut2 uses a longer
// one to show that presses shorter than the debounce time are ignored.
module tb_btn_pulse;

   localparam int D1 = 4;
   localparam int D2 = 1000;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic       bnt1, bnt2, bnt3, bnt4;
   logic [3:0] btn_level;
   logic       any_press;
   logic [3:0] pulses;

   logic       rst2_n;
   logic [3:0] raw2;
   logic       b2p1, b2p2, b2p3, b2p4;
   logic [3:0] level2;
   logic       any2;

   int checks;
   int failures;

   assign pulses = {bnt4, bnt3, bnt2, bnt1};

   btn_pulse #(.DEBOUNCE_CYC(D1), .CNT_W(3)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .bnt1      (bnt1),
      .bnt2      (bnt2),
      .bnt3      (bnt3),
      .bnt4      (bnt4),
      .btn_level (btn_level),
      .any_press (any_press)
   );

   btn_pulse #(.DEBOUNCE_CYC(D2), .CNT_W(10)) dut2 (
      .clk       (clk),
      .rst_n     (rst2_n),
      .btn_raw   (raw2),
      .bnt1      (b2p1),
      .bnt2      (b2p2),
      .bnt3      (b2p3),
      .bnt4      (b2p4),
      .btn_level (level2),
      .any_press (any2)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model for dut1: keeps the history of raw samples taken at every
   // rising edge since reset. The synchronised value seen at edge n is the raw
   // sample of edge n-2. A channel flips when the last D1 synchronised values,
   // all taken after its previous flip, disagree with its current level.
   logic [3:0] mRawHist [$];
   logic [3:0] mS2Hist  [$];
   int         mLastFlip [4];
   logic [3:0] mLevel;
   logic [3:0] mPulse;
   int         mN;
   logic [3:0] mS2Now;
   logic [3:0] mTmp;
   bit         mAllDiff;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mRawHist.delete();
         mS2Hist.delete();
         mLevel = '0;
         mPulse = '0;
         for (int ch = 0; ch < 4; ch++) mLastFlip[ch] = -1;
      end else begin
         mN     = mRawHist.size();
         mS2Now = (mN >= 2) ? mRawHist[mN-2] : 4'b0000;
         mRawHist.push_back(btn_raw);
         mS2Hist.push_back(mS2Now);
         mPulse = '0;
         for (int ch = 0; ch < 4; ch++) begin
            if (mN - mLastFlip[ch] >= D1) begin
               mAllDiff = 1'b1;
               for (int j = mN - D1 + 1; j <= mN; j++) begin
                  mTmp = mS2Hist[j];
                  if (mTmp[ch] == mLevel[ch]) mAllDiff = 1'b0;
               end
               if (mAllDiff) begin
                  mLevel[ch]    = ~mLevel[ch];
                  mLastFlip[ch] = mN;
                  mPulse[ch]    = mLevel[ch];
               end
            end
         end
      end
   end

   typedef struct {
      logic [3:0] raw;
      int         cycles;
      logic [3:0] expLevel;
      logic [3:0] expPulsed;
      int         expAny;
   } vec_t;

   vec_t vecs [11];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive both DUTs' buttons before the next rising edge, then return on the
   // following falling edge so outputs of that edge can be sampled.
   task automatic applyStimulus(input logic [3:0] raw, input logic [3:0] rawB);
      btn_raw = raw;
      raw2    = rawB;
      @(negedge clk);
   endtask

   task automatic resetDut1();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int         pCnt [4];
   int         anyCnt;
   int         pulseAt;
   int         levelAt;
   int         holdLeft [4];
   logic [3:0] curRaw;

   initial begin
      checks   = 0;
      failures = 0;
      btn_raw  = '0;
      raw2     = '0;
      rst_n    = 1'b0;
      rst2_n   = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("reset_level", {28'd0, btn_level}, 32'd0);
      checkOutput("reset_pulses", {27'd0, any_press, pulses}, 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      rst2_n = 1'b1;

      // Segment table: raw value, cycles held, level at end, buttons pulsed once, any_press cycles.
      vecs[0]  = '{4'b0000,  8, 4'b0000, 4'b0000, 0};
      vecs[1]  = '{4'b0001, 10, 4'b0001, 4'b0001, 1};
      vecs[2]  = '{4'b0001, 20, 4'b0001, 4'b0000, 0};
      vecs[3]  = '{4'b0000, 10, 4'b0000, 4'b0000, 0};
      vecs[4]  = '{4'b0100,  3, 4'b0000, 4'b0000, 0};
      vecs[5]  = '{4'b0000, 10, 4'b0000, 4'b0000, 0};
      vecs[6]  = '{4'b0100,  4, 4'b0000, 4'b0000, 0};
      vecs[7]  = '{4'b0000, 10, 4'b0000, 4'b0100, 1};
      vecs[8]  = '{4'b1111, 10, 4'b1111, 4'b1111, 1};
      vecs[9]  = '{4'b1010, 10, 4'b1010, 4'b0000, 0};
      vecs[10] = '{4'b0000, 10, 4'b0000, 4'b0000, 0};

      for (int v = 0; v < 11; v++) begin
         for (int b = 0; b < 4; b++) pCnt[b] = 0;
         anyCnt = 0;
         for (int c = 0; c < vecs[v].cycles; c++) begin
            applyStimulus(vecs[v].raw, 4'b0000);
            for (int b = 0; b < 4; b++) if (pulses[b]) pCnt[b]++;
            if (any_press) anyCnt++;
         end
         checkOutput($sformatf("vec%0d_level", v), {28'd0, btn_level}, {28'd0, vecs[v].expLevel});
         for (int b = 0; b < 4; b++)
            checkOutput($sformatf("vec%0d_pulses_b%0d", v, b + 1), pCnt[b], {31'd0, vecs[v].expPulsed[b]});
         checkOutput($sformatf("vec%0d_any", v), anyCnt, vecs[v].expAny);
      end

      // Bounce on button 2: 1,1,1,0 for 28 cycles, then steady 1 from cycle 28.
      resetDut1();
      pCnt[1] = 0;
      pulseAt = -1;
      levelAt = -1;
      for (int c = 0; c < 50; c++) begin
         applyStimulus({2'b00, (c >= 28) || (c % 4 != 3), 1'b0}, 4'b0000);
         if (bnt2) begin
            pCnt[1]++;
            pulseAt = c;
         end
         if (btn_level[1] && levelAt < 0) levelAt = c;
      end
      checkOutput("bounce_pulse_count", pCnt[1], 1);
      checkOutput("bounce_pulse_edge", pulseAt, 28 + D1 + 1);
      checkOutput("bounce_level_edge", levelAt, 28 + D1 + 1);

      // Reset mid-count with button 1 already held; both buttons held through reset.
      resetDut1();
      for (int c = 0; c < 8; c++) applyStimulus(4'b0001, 4'b0000);
      checkOutput("premid_level", {28'd0, btn_level}, 32'd1);
      for (int c = 0; c < 4; c++) applyStimulus(4'b1001, 4'b0000);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_level", {28'd0, btn_level}, 32'd0);
      checkOutput("midreset_pulses", {27'd0, any_press, pulses}, 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      pCnt[0] = 0;
      pCnt[3] = 0;
      pulseAt = -1;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(4'b1001, 4'b0000);
         if (bnt4) begin
            pCnt[3]++;
            pulseAt = c;
         end
         if (bnt1) pCnt[0]++;
      end
      checkOutput("afterreset_b4_count", pCnt[3], 1);
      checkOutput("afterreset_b4_edge", pulseAt, D1 + 1);
      checkOutput("afterreset_b1_count", pCnt[0], 1);

      // Random buttons against the reference model, with occasional resets.
      resetDut1();
      curRaw = '0;
      for (int b = 0; b < 4; b++) holdLeft[b] = 0;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            #1;
            checkOutput("rand_reset_level", {28'd0, btn_level}, 32'd0);
            checkOutput("rand_reset_pulses", {27'd0, any_press, pulses}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
         end
         for (int b = 0; b < 4; b++) begin
            if (holdLeft[b] == 0) begin
               curRaw[b]   = 1'($urandom_range(0, 1));
               holdLeft[b] = $urandom_range(1, 2 * D1 + 3);
            end
            holdLeft[b]--;
         end
         applyStimulus(curRaw, 4'b0000);
         checkOutput($sformatf("rand%0d_level", c), {28'd0, btn_level}, {28'd0, mLevel});
         checkOutput($sformatf("rand%0d_pulses", c), {28'd0, pulses}, {28'd0, mPulse});
         checkOutput($sformatf("rand%0d_any", c), {31'd0, any_press}, {31'd0, |mPulse});
      end

      // Long debounce: a press of half the debounce time is ignored entirely.
      btn_raw = '0;
      anyCnt  = 0;
      levelAt = -1;
      for (int c = 0; c < 1600; c++) begin
         applyStimulus(4'b0000, (c < D2 / 2) ? 4'b0001 : 4'b0000);
         if (any2) anyCnt++;
         if (level2 != 4'b0000 && levelAt < 0) levelAt = c;
      end
      checkOutput("long_short_pulses", anyCnt, 0);
      checkOutput("long_short_level", levelAt, -1);

      // Long debounce: a press longer than the debounce time fires exactly once.
      anyCnt  = 0;
      pulseAt = -1;
      for (int c = 0; c < 1200; c++) begin
         applyStimulus(4'b0000, 4'b0001);
         if (b2p1) pulseAt = c;
         if (any2) anyCnt++;
      end
      checkOutput("long_press_count", anyCnt, 1);
      checkOutput("long_press_edge", pulseAt, D2 + 1);
      checkOutput("long_press_level", {28'd0, level2}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
